// File: rtl/mjpeg_frame_packer_pkg.sv
// Shared types for the MJPEG frame packer: control state encoding and lane sizing.
package mjpeg_pack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ENCODE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int unsigned BYTE_W = 8;

    // Byte lanes per packed word; the write mask carries one bit per lane.
    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/mjpeg_frame_packer_byte_packer.sv
// Packs encoder bytes MSB-first into DATA_W words and holds one word for the write handshake.
module mjpeg_byte_packer
    import mjpeg_pack_pkg::*;
#(
    parameter int unsigned       DATA_W     = 128,
    parameter int unsigned       ADDR_W     = 28,
    parameter int unsigned       ADDR_INC   = 8,
    parameter logic [ADDR_W-1:0] WORD_LIMIT = 28'h0020000
) (
    input  logic                           rst_n,
    input  logic                           i_clk,
    input  logic                           i_clear,
    input  logic                           i_byte_valid,
    input  logic [7:0]                     i_byte,
    input  logic                           i_flush,
    input  logic [ADDR_W-1:0]              i_base_addr,
    input  logic                           i_wr_ready,
    output logic                           o_byte_acc,
    output logic                           o_flush_done,
    output logic                           o_overflow,
    output logic                           o_wr_valid,
    output logic [DATA_W-1:0]              o_wr_data,
    output logic [lane_count(DATA_W)-1:0]  o_wr_mask,
    output logic [ADDR_W-1:0]              o_wr_addr,
    output logic                           o_wr_last
);
    localparam int unsigned LANES = lane_count(DATA_W);
    localparam int unsigned CNT_W = $clog2(LANES + 1);

    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_word_idx;
    logic              r_ovf;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [LANES-1:0]  r_out_mask;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_last;

    logic              w_xfer, w_out_free, w_full, w_move, w_word_ok, w_load, w_drop_byte;
    logic [CNT_W-1:0]  w_lane;
    logic [LANES-1:0]  w_ones, w_tail_mask;

    always_comb begin
        w_xfer      = r_out_valid & i_wr_ready;
        w_out_free  = ~r_out_valid | w_xfer;
        w_full      = (r_cnt == CNT_W'(LANES));
        // A full accumulator only leaves when another byte pushes it out or on flush,
        // so the word carrying o_wr_last always holds data.
        w_move      = w_out_free & ((i_byte_valid & w_full) | (i_flush & (r_cnt != '0)));
        w_word_ok   = (r_word_idx < WORD_LIMIT);
        w_load      = w_move & w_word_ok;
        w_drop_byte = i_byte_valid & w_full & ~w_out_free;
        w_lane      = CNT_W'(LANES - 1) - r_cnt;
        w_ones      = '1;
        w_tail_mask = w_ones >> r_cnt;
    end

    assign o_byte_acc   = i_byte_valid & ~w_drop_byte;
    assign o_flush_done = i_flush & (r_cnt == '0) & w_out_free;
    assign o_overflow   = r_ovf;
    assign o_wr_valid   = r_out_valid;
    assign o_wr_data    = r_out_data;
    assign o_wr_mask    = r_out_mask;
    assign o_wr_addr    = r_out_addr;
    assign o_wr_last    = r_out_last;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_word_idx  <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (i_clear) begin
                r_acc      <= '0;
                r_cnt      <= '0;
                r_word_idx <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_load) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_acc;
                    r_out_mask  <= i_flush ? w_tail_mask : '0;
                    r_out_last  <= i_flush;
                    r_out_addr  <= i_base_addr + r_word_idx * ADDR_W'(ADDR_INC);
                    r_word_idx  <= r_word_idx + ADDR_W'(1);
                end
                if ((w_move & ~w_word_ok) | w_drop_byte) begin
                    r_ovf <= 1'b1;
                end
                if (o_byte_acc) begin
                    if (w_full) begin
                        r_acc <= {i_byte, (DATA_W - 8)'(0)};
                        r_cnt <= CNT_W'(1);
                    end else begin
                        r_acc[w_lane*8 +: 8] <= i_byte;
                        r_cnt                <= r_cnt + CNT_W'(1);
                    end
                end else if (w_move) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mjpeg_frame_packer.sv
// Camera-to-MJPEG frame controller: gates pixels into the encoder and writes the
// packed bitstream into a ring of frame buffers.
module mjpeg_frame_packer
    import mjpeg_pack_pkg::*;
#(
    parameter int unsigned       DATA_W       = 128,
    parameter int unsigned       ADDR_W       = 28,
    parameter int unsigned       NUM_BUF      = 2,
    parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0100000,
    parameter int unsigned       ADDR_INC     = 8,
    parameter int unsigned       SKIP         = 0
) (
    input  logic                          rst_n,
    input  logic                          i_cam_pclk,
    input  logic                          i_cam_vsync,
    input  logic                          i_cam_de,
    input  logic                          i_cam_rgb888_pclk,
    input  logic [23:0]                   i_cam_data,
    output logic                          o_mjpeg_rst,
    output logic                          o_mjpeg_de,
    output logic [23:0]                   o_mjpeg_data,
    input  logic                          i_mjpeg_de,
    input  logic [7:0]                    i_mjpeg_data,
    input  logic                          i_mjpeg_down,
    output logic                          o_wr_valid,
    input  logic                          i_wr_ready,
    output logic [DATA_W-1:0]             o_wr_data,
    output logic [DATA_W/8-1:0]           o_wr_mask,
    output logic [ADDR_W-1:0]             o_wr_addr,
    output logic                          o_wr_last,
    output logic                          o_frame_done,
    output logic [31:0]                   o_frame_len,
    output logic [$clog2(NUM_BUF)-1:0]    o_frame_buf,
    output logic                          o_overflow
);
    localparam int unsigned       BUF_W      = $clog2(NUM_BUF);
    localparam logic [ADDR_W-1:0] WORD_LIMIT = FRAME_STRIDE / ADDR_W'(ADDR_INC);

    state_t             r_state, w_next;
    logic               r_vsync_d, r_de_d;
    logic [15:0]        r_skip_cnt;
    logic               r_gate, r_mjpeg_rst;
    logic [31:0]        r_byte_cnt, r_frame_len;
    logic [BUF_W-1:0]   r_buf_idx, r_frame_buf;

    logic               w_vs_rise, w_de_rise, w_arm_go, w_flush, w_flush_done;
    logic               w_enter_done, w_byte_valid, w_byte_acc;
    logic [ADDR_W-1:0]  w_base;

    always_comb begin
        w_vs_rise    = i_cam_vsync & ~r_vsync_d;
        w_de_rise    = i_cam_de & ~r_de_d;
        w_arm_go     = (r_state == ST_ARM) & w_de_rise;
        w_flush      = (r_state == ST_FLUSH);
        w_byte_valid = (r_state == ST_ENCODE) & i_mjpeg_de;
        w_enter_done = w_flush & w_flush_done;
        w_base       = FRAME_BASE + ADDR_W'(r_buf_idx) * FRAME_STRIDE;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_vs_rise && r_skip_cnt == 16'(SKIP)) w_next = ST_ARM;
            ST_ARM:    if (w_de_rise) w_next = ST_ENCODE;
            ST_ENCODE: if (i_mjpeg_down) w_next = ST_FLUSH;
            ST_FLUSH:  if (w_flush_done) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge i_cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_d   <= 1'b0;
            r_de_d      <= 1'b0;
            r_skip_cnt  <= '0;
            r_gate      <= 1'b0;
            r_mjpeg_rst <= 1'b0;
            r_byte_cnt  <= '0;
            r_frame_len <= '0;
            r_frame_buf <= '0;
            r_buf_idx   <= '0;
        end else begin
            r_vsync_d <= i_cam_vsync;
            r_de_d    <= i_cam_de;
            if (r_state == ST_IDLE && w_vs_rise) begin
                r_skip_cnt <= (r_skip_cnt == 16'(SKIP)) ? '0 : r_skip_cnt + 16'd1;
            end
            if (w_arm_go)       r_gate <= 1'b1;
            else if (w_vs_rise) r_gate <= 1'b0;
            if (w_arm_go)                                     r_mjpeg_rst <= 1'b1;
            else if (r_state == ST_ENCODE && i_mjpeg_down)    r_mjpeg_rst <= 1'b0;
            if (w_arm_go)                            r_byte_cnt <= '0;
            else if (w_byte_acc && r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 32'd1;
            // Latch status on entry to DONE so it is valid while o_frame_done is high.
            if (w_enter_done) begin
                r_frame_len <= r_byte_cnt;
                r_frame_buf <= r_buf_idx;
            end
            if (r_state == ST_DONE) begin
                r_buf_idx <= (r_buf_idx == BUF_W'(NUM_BUF - 1)) ? '0 : r_buf_idx + BUF_W'(1);
            end
        end
    end

    // The gate term includes the arming cycle so the first pixel of the frame passes.
    assign o_mjpeg_de   = i_cam_rgb888_pclk & i_cam_de & (r_gate | w_arm_go);
    assign o_mjpeg_data = i_cam_data;
    assign o_mjpeg_rst  = r_mjpeg_rst;
    assign o_frame_done = (r_state == ST_DONE);
    assign o_frame_len  = r_frame_len;
    assign o_frame_buf  = r_frame_buf;

    mjpeg_byte_packer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .ADDR_INC   (ADDR_INC),
        .WORD_LIMIT (WORD_LIMIT)
    ) u_packer (
        .rst_n        (rst_n),
        .i_clk        (i_cam_pclk),
        .i_clear      (w_arm_go),
        .i_byte_valid (w_byte_valid),
        .i_byte       (i_mjpeg_data),
        .i_flush      (w_flush),
        .i_base_addr  (w_base),
        .i_wr_ready   (i_wr_ready),
        .o_byte_acc   (w_byte_acc),
        .o_flush_done (w_flush_done),
        .o_overflow   (o_overflow),
        .o_wr_valid   (o_wr_valid),
        .o_wr_data    (o_wr_data),
        .o_wr_mask    (o_wr_mask),
        .o_wr_addr    (o_wr_addr),
        .o_wr_last    (o_wr_last)
    );

endmodule
